// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse command/response bytes and the init FSM encoding.
package mouse_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_RST,
    ST_WAIT_ACK_RST,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_WAIT_ACK_EN,
    ST_STREAM,
    ST_FAIL
  } state_t;

  // Byte the mouse must send next while the FSM sits in a WAIT_* state.
  function automatic logic [7:0] expected_rsp(input state_t s);
    case (s)
      ST_WAIT_BAT: return RSP_BAT_OK;
      ST_WAIT_ID:  return RSP_ID;
      default:     return RSP_ACK;
    endcase
  endfunction

  function automatic state_t next_after_rsp(input state_t s);
    case (s)
      ST_WAIT_ACK_RST: return ST_WAIT_BAT;
      ST_WAIT_BAT:     return ST_WAIT_ID;
      ST_WAIT_ID:      return ST_SEND_EN;
      default:         return ST_STREAM;
    endcase
  endfunction

endpackage

// File: rtl/mouse_cursor_accum.sv
// Turns a complete 3-byte PS/2 movement packet into a clamped cursor position and button state.
module mouse_cursor_accum #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_vld_p0,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       l_click,
  output logic       m_click,
  output logic       r_click,
  output logic       packet_strobe
);

  localparam logic signed [10:0] X_MAX = 11'(SCREEN_WIDTH - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_HEIGHT - 1);

  function automatic logic [8:0] clamp_axis(input logic signed [10:0] v,
                                            input logic signed [10:0] vmax);
    if (v < 11'sd0)
      return '0;
    else if (v > vmax)
      return vmax[8:0];
    else
      return v[8:0];
  endfunction

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] x_sum;
  logic signed [10:0] y_sum;
  logic               apply;

  assign dx    = {{3{b0[4]}}, b1};
  assign dy    = {{3{b0[5]}}, b2};
  assign x_sum = $signed({2'b00, x}) + dx;
  // Screen y grows downward while PS/2 y grows upward.
  assign y_sum = $signed({2'b00, y}) - dy;
  assign apply = pkt_vld_p0 && b0[3];

  // Stage p0 -> p1: packet bytes to registered cursor/button outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      x             <= 9'(SCREEN_WIDTH / 2);
      y             <= 9'(SCREEN_HEIGHT / 2);
      l_click       <= 1'b0;
      m_click       <= 1'b0;
      r_click       <= 1'b0;
      packet_strobe <= 1'b0;
    end else begin
      packet_strobe <= apply;
      if (apply) begin
        l_click <= b0[0];
        r_click <= b0[1];
        m_click <= b0[2];
        if (!b0[6]) x <= clamp_axis(x_sum, X_MAX);
        if (!b0[7]) y <= clamp_axis(y_sum, Y_MAX);
      end
    end
  end

endmodule

// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse bring-up FSM (reset, BAT, ID, enable reporting) with retries, then packet assembly.
module mouse_init_ctrl
  import mouse_pkg::*;
#(
  parameter int SCREEN_WIDTH   = 160,
  parameter int SCREEN_HEIGHT  = 120,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES     = 100_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       streaming,
  output logic       init_fail,
  output logic       packet_strobe,
  output logic       l_click,
  output logic       m_click,
  output logic       r_click,
  output logic [8:0] x,
  output logic [8:0] y
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [1:0]      byte_idx;
  logic [7:0]      b0_q;
  logic [7:0]      b1_q;
  logic            wait_fail;
  logic            pkt_vld_p0;

  // rx_error outranks a simultaneous rx_valid.
  assign wait_fail  = rx_error
                   || (rx_valid && (rx_data != expected_rsp(state)))
                   || (wait_cnt == CW'(TIMEOUT_CYCLES));
  assign pkt_vld_p0 = (state == ST_STREAM) && rx_valid && !rx_error && !start
                   && (byte_idx == 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      streaming <= 1'b0;
      init_fail <= 1'b0;
      retry_cnt <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
    end else if (start) begin
      // Restart from any state; SEND_RST re-raises tx_valid one cycle later.
      state     <= ST_SEND_RST;
      tx_valid  <= 1'b0;
      streaming <= 1'b0;
      init_fail <= 1'b0;
      retry_cnt <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
    end else begin
      wait_cnt <= rx_valid ? '0 : wait_cnt + 1'b1;
      case (state)
        ST_SEND_RST, ST_SEND_EN: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= (state == ST_SEND_RST) ? CMD_RESET : CMD_ENABLE;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= (state == ST_SEND_RST) ? ST_WAIT_ACK_RST : ST_WAIT_ACK_EN;
            wait_cnt <= '0;
          end
        end
        ST_WAIT_ACK_RST, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK_EN: begin
          if (wait_fail) begin
            retry_cnt <= retry_cnt + 1'b1;
            wait_cnt  <= '0;
            if (retry_cnt < RW'(MAX_RETRIES - 1)) begin
              state <= ST_SEND_RST;
            end else begin
              state     <= ST_FAIL;
              init_fail <= 1'b1;
            end
          end else if (rx_valid) begin
            state     <= next_after_rsp(state);
            wait_cnt  <= '0;
            streaming <= (state == ST_WAIT_ACK_EN);
          end
        end
        ST_STREAM: begin
          if (rx_error) begin
            byte_idx <= '0;
          end else if (rx_valid) begin
            case (byte_idx)
              2'd0: if (rx_data[3]) begin
                b0_q     <= rx_data;
                byte_idx <= 2'd1;
              end
              2'd1: begin
                b1_q     <= rx_data;
                byte_idx <= 2'd2;
              end
              default: byte_idx <= 2'd0;
            endcase
          end else if ((byte_idx != 2'd0) && (wait_cnt == CW'(GAP_CYCLES))) begin
            byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mouse_cursor_accum #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_accum (
    .clock        (clock),
    .reset        (reset),
    .pkt_vld_p0   (pkt_vld_p0),
    .b0           (b0_q),
    .b1           (b1_q),
    .b2           (rx_data),
    .x            (x),
    .y            (y),
    .l_click      (l_click),
    .m_click      (m_click),
    .r_click      (r_click),
    .packet_strobe(packet_strobe)
  );

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Directed bench for mouse_init_ctrl: bring-up, retries, packet decode, clamping and interruptions.
module tb_mouse_init_ctrl;

  localparam int TMO = 200;
  localparam int GAP = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, streaming, init_fail, packet_strobe;
  logic       l_click, m_click, r_click;
  logic [8:0] x, y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mouse_init_ctrl #(
    .SCREEN_WIDTH(160), .SCREEN_HEIGHT(120),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .MAX_RETRIES(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .streaming(streaming), .init_fail(init_fail), .packet_strobe(packet_strobe),
    .l_click(l_click), .m_click(m_click), .r_click(r_click),
    .x(x), .y(y)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic send_err();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
  endtask

  // Waits for a byte transfer on the tx handshake; returns after the transfer edge.
  task automatic wait_tx(output logic [7:0] d, output bit ok);
    ok = 1'b0; d = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid && tx_ready) begin
        d = tx_data; ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic bring_up();
    logic [7:0] d;
    bit ok;
    pulse_start();
    wait_tx(d, ok);
    send3(8'hFA, 8'hAA, 8'h00);
    wait_tx(d, ok);
    send_byte(8'hFA);
  endtask

  task automatic test_reset();
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_tests++; if ({streaming, init_fail, packet_strobe} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {streaming, init_fail, packet_strobe}); end
    n_tests++; if ({l_click, m_click, r_click} !== 3'b000) begin n_fail++; $display("FAIL reset_clicks: got %b expected 000", {l_click, m_click, r_click}); end
    n_tests++; if (x !== 9'd80) begin n_fail++; $display("FAIL reset_x: got %0d expected 80", x); end
    n_tests++; if (y !== 9'd60) begin n_fail++; $display("FAIL reset_y: got %0d expected 60", y); end
  endtask

  task automatic test_normal_init();
    logic [7:0] d;
    bit ok;
    pulse_start();
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hFF) begin n_fail++; $display("FAIL init_cmd_reset: got %h (ok=%0d) expected ff", d, ok); end
    send3(8'hFA, 8'hAA, 8'h00);
    n_tests++; if (streaming !== 1'b0) begin n_fail++; $display("FAIL init_early_stream: got %b expected 0", streaming); end
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hF4) begin n_fail++; $display("FAIL init_cmd_enable: got %h (ok=%0d) expected f4", d, ok); end
    send_byte(8'hFA);
    n_tests++; if (streaming !== 1'b1) begin n_fail++; $display("FAIL init_streaming: got %b expected 1", streaming); end
    n_tests++; if (init_fail !== 1'b0) begin n_fail++; $display("FAIL init_fail_flag: got %b expected 0", init_fail); end
  endtask

  task automatic test_packet_decode();
    send_byte(8'h09); send_byte(8'h05);
    n_tests++; if (packet_strobe !== 1'b0) begin n_fail++; $display("FAIL decode_early_strobe: got %b expected 0", packet_strobe); end
    send_byte(8'h03);
    n_tests++; if (packet_strobe !== 1'b1) begin n_fail++; $display("FAIL decode_strobe: got %b expected 1", packet_strobe); end
    n_tests++; if ({l_click, m_click, r_click} !== 3'b100) begin n_fail++; $display("FAIL decode_clicks: got %b expected 100", {l_click, m_click, r_click}); end
    n_tests++; if (x !== 9'd85) begin n_fail++; $display("FAIL decode_x: got %0d expected 85", x); end
    n_tests++; if (y !== 9'd57) begin n_fail++; $display("FAIL decode_y: got %0d expected 57", y); end
    tick();
    n_tests++; if (packet_strobe !== 1'b0) begin n_fail++; $display("FAIL decode_strobe_width: got %b expected 0", packet_strobe); end
  endtask

  task automatic test_clamp_negative();
    do_reset();
    bring_up();
    n_tests++; if (streaming !== 1'b1) begin n_fail++; $display("FAIL clamp_bringup: got %b expected 1", streaming); end
    for (int k = 1; k <= 4; k++) begin
      send3(8'h18, 8'hF0, 8'h00);
      n_tests++; if (x !== 9'(80 - 16 * k)) begin n_fail++; $display("FAIL clamp_step%0d_x: got %0d expected %0d", k, x, 80 - 16 * k); end
    end
    send3(8'h18, 8'h80, 8'h00);
    n_tests++; if (x !== 9'd0) begin n_fail++; $display("FAIL clamp_low_x: got %0d expected 0", x); end
    n_tests++; if (y !== 9'd60) begin n_fail++; $display("FAIL clamp_y_still: got %0d expected 60", y); end
  endtask

  task automatic test_overflow_resync();
    send3(8'h48, 8'h7F, 8'h01);
    n_tests++; if (x !== 9'd0) begin n_fail++; $display("FAIL ovf_x_held: got %0d expected 0", x); end
    n_tests++; if (y !== 9'd59) begin n_fail++; $display("FAIL ovf_y: got %0d expected 59", y); end
    send_byte(8'h02);
    send3(8'h08, 8'h01, 8'h00);
    n_tests++; if (x !== 9'd1) begin n_fail++; $display("FAIL resync_x: got %0d expected 1", x); end
    send3(8'h08, 8'hFF, 8'h00);
    n_tests++; if (x !== 9'd159) begin n_fail++; $display("FAIL clamp_high_x: got %0d expected 159", x); end
    send3(8'h28, 8'h00, 8'h80);
    n_tests++; if (y !== 9'd119) begin n_fail++; $display("FAIL clamp_high_y: got %0d expected 119", y); end
    send3(8'h0E, 8'h00, 8'h00);
    n_tests++; if ({l_click, m_click, r_click} !== 3'b011) begin n_fail++; $display("FAIL buttons_mr: got %b expected 011", {l_click, m_click, r_click}); end
  endtask

  task automatic test_rx_error_stream();
    send_byte(8'h08);
    send_err();
    send3(8'h18, 8'hFF, 8'h00);
    n_tests++; if (x !== 9'd158) begin n_fail++; $display("FAIL rxerr_x: got %0d expected 158", x); end
    n_tests++; if (y !== 9'd119) begin n_fail++; $display("FAIL rxerr_y: got %0d expected 119", y); end
  endtask

  task automatic test_gap();
    send_byte(8'h08); send_byte(8'h05);
    repeat (GAP + 20) tick();
    send3(8'h18, 8'hFE, 8'h00);
    n_tests++; if (x !== 9'd156) begin n_fail++; $display("FAIL gap_discard_x: got %0d expected 156", x); end
    send_byte(8'h08);
    repeat (GAP - 10) tick();
    send_byte(8'h01); send_byte(8'h00);
    n_tests++; if (x !== 9'd157) begin n_fail++; $display("FAIL gap_short_x: got %0d expected 157", x); end
  endtask

  task automatic test_interrupt();
    logic [7:0] d;
    bit ok;
    bit held;
    pulse_start();
    n_tests++; if ({streaming, tx_valid} !== 2'b00) begin n_fail++; $display("FAIL restart_drop: got %b expected 00", {streaming, tx_valid}); end
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hFF) begin n_fail++; $display("FAIL restart_cmd: got %h (ok=%0d) expected ff", d, ok); end
    send3(8'hFA, 8'hAA, 8'h00);
    tx_ready = 1'b0;
    tick();
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hF4) held = 1'b0;
      tick();
    end
    n_tests++; if (!held) begin n_fail++; $display("FAIL tx_hold: got valid=%b data=%h expected held f4", tx_valid, tx_data); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop_tx: got %b expected 0", tx_valid); end
    n_tests++; if (x !== 9'd80 || y !== 9'd60) begin n_fail++; $display("FAIL reset_cursor: got %0d,%0d expected 80,60", x, y); end
    tx_ready = 1'b1;
    held = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid !== 1'b0) held = 1'b1;
      tick();
    end
    n_tests++; if (held || streaming !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got tx_seen=%0d streaming=%b expected 0,0", held, streaming); end
  endtask

  task automatic test_bad_response();
    logic [7:0] d;
    bit ok;
    pulse_start();
    wait_tx(d, ok);
    send_byte(8'h55);
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hFF) begin n_fail++; $display("FAIL retry_after_bad: got %h (ok=%0d) expected ff", d, ok); end
    send_byte(8'hFA);
    send_err();
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hFF) begin n_fail++; $display("FAIL retry_after_err: got %h (ok=%0d) expected ff", d, ok); end
    send3(8'hFA, 8'hAA, 8'h00);
    wait_tx(d, ok);
    send_byte(8'hFA);
    n_tests++; if ({streaming, init_fail} !== 2'b10) begin n_fail++; $display("FAIL third_attempt: got %b expected 10", {streaming, init_fail}); end
  endtask

  task automatic test_retries();
    logic [7:0] d;
    bit ok;
    int nff;
    int cyc;
    do_reset();
    pulse_start();
    nff = 0; cyc = 0;
    for (int i = 0; i < 3 * TMO + 100; i++) begin
      if (init_fail) break;
      if (tx_valid && tx_ready && tx_data == 8'hFF) nff++;
      tick();
      cyc++;
    end
    n_tests++; if (init_fail !== 1'b1) begin n_fail++; $display("FAIL retries_init_fail: got %b expected 1", init_fail); end
    n_tests++; if (nff != 3) begin n_fail++; $display("FAIL retries_ff_count: got %0d expected 3", nff); end
    n_tests++; if (cyc < 3 * TMO || cyc > 3 * TMO + 30) begin n_fail++; $display("FAIL retries_duration: got %0d cycles expected %0d..%0d", cyc, 3 * TMO, 3 * TMO + 30); end
    n_tests++; if (streaming !== 1'b0) begin n_fail++; $display("FAIL retries_streaming: got %b expected 0", streaming); end
    pulse_start();
    n_tests++; if (init_fail !== 1'b0) begin n_fail++; $display("FAIL fail_restart_flag: got %b expected 0", init_fail); end
    wait_tx(d, ok);
    n_tests++; if (!ok || d !== 8'hFF) begin n_fail++; $display("FAIL fail_restart_cmd: got %h (ok=%0d) expected ff", d, ok); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_normal_init();
    test_packet_decode();
    test_clamp_negative();
    test_overflow_resync();
    test_rx_error_stream();
    test_gap();
    test_interrupt();
    test_bad_response();
    test_retries();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
